// File: rtl/rv32i_types.sv
// Shared rename-stage types: machine widths, popcount helper and the allocator FSM states.
package rv32i_types;

  localparam int unsigned WAY       = 2;
  localparam int unsigned PRF_ENTRY = 64;
  localparam int unsigned PRF_WIDTH = $clog2(PRF_ENTRY);
  localparam int unsigned CNT_W     = $clog2(WAY + 1);

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } rn_state_e;

  // Number of set bits in a per-way mask.
  function automatic logic [CNT_W-1:0] popcount(input logic [WAY-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < int'(WAY); i++) n = n + CNT_W'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/rename_alloc_ctrl_if.sv
// Rename/commit handshake between the rename stage (master) and the physical register allocator (slave).
interface rename_alloc_ctrl_if #(
  parameter int unsigned WAY       = rv32i_types::WAY,
  parameter int unsigned PRF_WIDTH = rv32i_types::PRF_WIDTH
);

  logic [WAY-1:0]                rn_valid;
  logic [WAY-1:0]                rn_rd_we;
  logic                          rn_ready;
  logic [WAY-1:0]                rat_en;
  logic [WAY-1:0][PRF_WIDTH-1:0] rat_new_phy;
  logic [WAY-1:0]                commit_valid;
  logic [WAY-1:0][PRF_WIDTH-1:0] commit_old_phy;
  logic                          br_mispredict_flush;
  logic [PRF_WIDTH:0]            free_count;

  modport master (
    output rn_valid, rn_rd_we, commit_valid, commit_old_phy, br_mispredict_flush,
    input  rn_ready, rat_en, rat_new_phy, free_count
  );

  modport slave (
    input  rn_valid, rn_rd_we, commit_valid, commit_old_phy, br_mispredict_flush,
    output rn_ready, rat_en, rat_new_phy, free_count
  );

endinterface

// File: rtl/prf_free_list.sv
// Circular free list of physical registers with speculative head, commit head and tail pointers.
module prf_free_list #(
  parameter int unsigned PRF_ENTRY = rv32i_types::PRF_ENTRY,
  parameter int unsigned PRF_WIDTH = $clog2(PRF_ENTRY)
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [rv32i_types::WAY-1:0]                 req,
  input  logic                                        alloc_go,
  input  logic [rv32i_types::WAY-1:0]                 commit_valid,
  input  logic [rv32i_types::WAY-1:0][PRF_WIDTH-1:0]  commit_old_phy,
  input  logic                                        flush,
  output logic [rv32i_types::WAY-1:0][PRF_WIDTH-1:0]  new_phy,
  output logic [PRF_WIDTH:0]                          free_count
);

  import rv32i_types::*;

  localparam int unsigned PTR_W = PRF_WIDTH + 1;

  logic [PRF_WIDTH-1:0]          fl_q [PRF_ENTRY];
  logic [PTR_W-1:0]              spec_head_q, commit_head_q, tail_q, free_count_q;
  logic [PTR_W-1:0]              spec_head_d, commit_head_d, tail_d, free_count_d;
  logic [WAY-1:0]                free_mask;
  logic [WAY-1:0][PRF_WIDTH-1:0] wr_idx;
  logic [CNT_W-1:0]              n_alloc, n_commit, n_free;

  // Way k reads the slot after the requesting ways below it.
  always_comb begin
    logic [CNT_W-1:0] ofs;
    ofs     = '0;
    new_phy = '0;
    for (int k = 0; k < int'(WAY); k++) begin
      new_phy[k] = fl_q[spec_head_q[PRF_WIDTH-1:0] + PRF_WIDTH'(ofs)];
      ofs        = ofs + CNT_W'(req[k]);
    end
  end

  // p0 is the permanent x0 mapping, so a zero old mapping is never returned.
  always_comb begin
    logic [CNT_W-1:0] ofs;
    ofs       = '0;
    free_mask = '0;
    wr_idx    = '0;
    for (int k = 0; k < int'(WAY); k++) begin
      free_mask[k] = commit_valid[k] && (commit_old_phy[k] != '0);
      wr_idx[k]    = tail_q[PRF_WIDTH-1:0] + PRF_WIDTH'(ofs);
      ofs          = ofs + CNT_W'(free_mask[k]);
    end
  end

  assign n_alloc  = alloc_go ? popcount(req) : '0;
  assign n_commit = popcount(commit_valid);
  assign n_free   = popcount(free_mask);

  // A flush rewinds speculation to the post-commit point of this cycle.
  always_comb begin
    commit_head_d = commit_head_q + PTR_W'(n_commit);
    tail_d        = tail_q + PTR_W'(n_free);
    spec_head_d   = spec_head_q + PTR_W'(n_alloc);
    free_count_d  = free_count_q - PTR_W'(n_alloc) + PTR_W'(n_free);
    if (flush) begin
      spec_head_d  = commit_head_d;
      free_count_d = tail_d - commit_head_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      spec_head_q   <= '0;
      commit_head_q <= '0;
      tail_q        <= PTR_W'(PRF_ENTRY - 1);
      free_count_q  <= PTR_W'(PRF_ENTRY - 1);
    end else begin
      spec_head_q   <= spec_head_d;
      commit_head_q <= commit_head_d;
      tail_q        <= tail_d;
      free_count_q  <= free_count_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < PRF_ENTRY; i++)
        fl_q[i] <= (i < PRF_ENTRY - 1) ? PRF_WIDTH'(i + 1) : '0;
    end else begin
      for (int k = 0; k < int'(WAY); k++)
        if (free_mask[k]) fl_q[wr_idx[k]] <= commit_old_phy[k];
    end
  end

  assign free_count = free_count_q;

endmodule

// File: rtl/rename_alloc_ctrl.sv
// Rename-group allocator: all-or-nothing acceptance, mispredict recovery FSM, free list instance.
module rename_alloc_ctrl #(
  parameter int unsigned PRF_ENTRY  = rv32i_types::PRF_ENTRY,
  parameter int unsigned ARCH_ENTRY = 32,
  parameter int unsigned PRF_WIDTH  = $clog2(PRF_ENTRY)
) (
  input logic                clk,
  input logic                rst,
  rename_alloc_ctrl_if.slave bus
);

  import rv32i_types::*;

  localparam int unsigned PTR_W = PRF_WIDTH + 1;

  // Every architectural register needs a mapping with at least one spare to rename into.
  if (ARCH_ENTRY >= PRF_ENTRY) begin : g_bad_cfg
    $error("rename_alloc_ctrl: PRF_ENTRY must exceed ARCH_ENTRY");
  end

  rn_state_e        state_q, state_d;
  logic [WAY-1:0]   req;
  logic [CNT_W-1:0] need;
  logic [PTR_W-1:0] fc;
  logic             ready;
  logic             accept;

  assign req  = bus.rn_valid & bus.rn_rd_we;
  assign need = popcount(req);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= RUN;
    else      state_q <= state_d;
  end

  // Grants only in RUN; each flush buys one RECOVER cycle.
  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    case (state_q)
      RUN: begin
        ready = !bus.br_mispredict_flush && (fc >= PTR_W'(need));
        if (bus.br_mispredict_flush) state_d = RECOVER;
      end
      RECOVER: state_d = bus.br_mispredict_flush ? RECOVER : RUN;
      default: state_d = RUN;
    endcase
  end

  assign accept         = ready & rst;
  assign bus.rn_ready   = accept;
  assign bus.rat_en     = req & {WAY{accept}};
  assign bus.free_count = fc;

  prf_free_list #(
    .PRF_ENTRY (PRF_ENTRY),
    .PRF_WIDTH (PRF_WIDTH)
  ) u_free_list (
    .clk            (clk),
    .rst            (rst),
    .req            (req),
    .alloc_go       (accept),
    .commit_valid   (bus.commit_valid),
    .commit_old_phy (bus.commit_old_phy),
    .flush          (bus.br_mispredict_flush),
    .new_phy        (bus.rat_new_phy),
    .free_count     (fc)
  );

endmodule
